lock_waitq: RTL and testbench

Queuing lock arbiter for the accelerator lock service. It accepts lock and unlock commands from up to 16 requesters on a shared AXI-Stream, and tracks the owner and pending waiters of each lock. A contended lock is granted later instead of being refused. On unlock, ownership passes round-robin to the next waiter, which receives its grant without retrying.

---
 rtl/lock_waitq.sv | 223 ++++++++++++++++++++++
 tb/tb_lock_waitq.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_waitq.sv
// lock_waitq: queuing lock arbiter for the accelerator lock service.
// Lock/unlock commands arrive on a shared AXI-Stream from up to 16 requesters.
// A contended lock queues its requester, and an owner unlock hands the lock
// round-robin to the next waiter, which receives an unsolicited grant.
// Optional feature macro: LOCK_WAITQ_TRYLOCK_EN enables opcode 0x05 (trylock).
// Trylock is a non-queuing lock that is refused immediately when contended.

module lock_waitq #(
  parameter int NUM_LOCKS = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [63:0] inStream_TDATA,
  input  logic        inStream_TVALID,
  input  logic [3:0]  inStream_TID,
  output logic        inStream_TREADY,
  output logic [7:0]  outStream_TDATA,
  output logic        outStream_TVALID,
  input  logic        outStream_TREADY,
  output logic [3:0]  outStream_TDEST
);

  localparam int IDX_W = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
  localparam logic [7:0] NUM_LOCKS_B = 8'(NUM_LOCKS);

  localparam logic [7:0] OP_LOCK    = 8'h04;
  localparam logic [7:0] OP_UNLOCK  = 8'h06;
`ifdef LOCK_WAITQ_TRYLOCK_EN
  localparam logic [7:0] OP_TRYLOCK = 8'h05;
`endif

  localparam logic [7:0] ACK_GRANT  = 8'h01;
  localparam logic [7:0] ACK_REFUSE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SCAN,
    ACK
  } stateT;

  stateT       state;
  logic        inReady;
  logic        outValid;
  logic [7:0]  outData;
  logic [3:0]  outDest;

  logic [7:0]  cmdOp;
  logic [7:0]  cmdId;
  logic [3:0]  cmdTid;

  logic        lockedQ  [NUM_LOCKS];
  logic [3:0]  ownerQ   [NUM_LOCKS];
  logic [15:0] pendingQ [NUM_LOCKS];

  logic [IDX_W-1:0] lockIdx;
  logic        inRange;
  logic        curLocked;
  logic [3:0]  curOwner;
  logic [15:0] curPending;

  logic        isLock;
  logic        isTry;
  logic        isUnlock;

  logic        execAck;
  logic [7:0]  execData;
  logic        execTake;
  logic        execQueue;
  logic        execFree;
  logic        execScan;

  logic [3:0]  nextTid;
  logic [3:0]  cand;
  logic        found;

  // Payload bits above the lock ID carry nothing for this block.
  logic        unusedTdata;
  assign unusedTdata = ^inStream_TDATA[63:16];

  assign inStream_TREADY  = inReady;
  assign outStream_TVALID = outValid;
  assign outStream_TDATA  = outData;
  assign outStream_TDEST  = outDest;

  // Decode the latched command and look up the state of the addressed lock.
  always_comb begin
    lockIdx    = cmdId[IDX_W-1:0];
    inRange    = (cmdId < NUM_LOCKS_B);
    curLocked  = lockedQ[lockIdx];
    curOwner   = ownerQ[lockIdx];
    curPending = pendingQ[lockIdx];
    isLock     = (cmdOp == OP_LOCK);
    isUnlock   = (cmdOp == OP_UNLOCK);
    isTry      = 1'b0;
`ifdef LOCK_WAITQ_TRYLOCK_EN
    isTry      = (cmdOp == OP_TRYLOCK);
`endif
  end

  // Work out what the EXEC state does with the current command.
  always_comb begin
    execAck   = 1'b0;
    execData  = ACK_REFUSE;
    execTake  = 1'b0;
    execQueue = 1'b0;
    execFree  = 1'b0;
    execScan  = 1'b0;
    if (isLock || isTry) begin
      if (!inRange) begin
        execAck = 1'b1;
      end else if (!curLocked) begin
        execAck  = 1'b1;
        execData = ACK_GRANT;
        execTake = 1'b1;
      end else if (curOwner == cmdTid) begin
        execAck  = 1'b1;
        execData = ACK_GRANT;
      end else if (isTry) begin
        execAck = 1'b1;
      end else begin
        execQueue = 1'b1;
      end
    end else if (isUnlock && inRange && curLocked && (curOwner == cmdTid)) begin
      if (curPending == 16'h0000) begin
        execFree = 1'b1;
      end else begin
        execScan = 1'b1;
      end
    end
  end

  // Round-robin search for the next waiter, starting just above the owner.
  always_comb begin
    nextTid = curOwner;
    cand    = curOwner;
    found   = 1'b0;
    for (int i = 1; i < 16; i++) begin
      cand = curOwner + 4'(i);
      if (!found && curPending[cand]) begin
        nextTid = cand;
        found   = 1'b1;
      end
    end
  end

  // Command FSM with registered stream outputs and the per-lock state table.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      outData  <= 8'h00;
      outDest  <= 4'h0;
      cmdOp    <= 8'h00;
      cmdId    <= 8'h00;
      cmdTid   <= 4'h0;
      for (int i = 0; i < NUM_LOCKS; i++) begin
        lockedQ[i]  <= 1'b0;
        ownerQ[i]   <= 4'h0;
        pendingQ[i] <= 16'h0000;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (inReady && inStream_TVALID) begin
            cmdOp   <= inStream_TDATA[7:0];
            cmdId   <= inStream_TDATA[15:8];
            cmdTid  <= inStream_TID;
            inReady <= 1'b0;
            state   <= EXEC;
          end else begin
            inReady <= 1'b1;
          end
        end
        EXEC: begin
          state   <= IDLE;
          inReady <= 1'b1;
          if (execTake) begin
            lockedQ[lockIdx] <= 1'b1;
            ownerQ[lockIdx]  <= cmdTid;
          end
          if (execQueue) begin
            pendingQ[lockIdx][cmdTid] <= 1'b1;
          end
          if (execFree) begin
            lockedQ[lockIdx] <= 1'b0;
          end
          if (execScan) begin
            state   <= SCAN;
            inReady <= 1'b0;
          end
          if (execAck) begin
            state    <= ACK;
            inReady  <= 1'b0;
            outValid <= 1'b1;
            outData  <= execData;
            outDest  <= cmdTid;
          end
        end
        SCAN: begin
          ownerQ[lockIdx]            <= nextTid;
          pendingQ[lockIdx][nextTid] <= 1'b0;
          outValid                   <= 1'b1;
          outData                    <= ACK_GRANT;
          outDest                    <= nextTid;
          state                      <= ACK;
        end
        ACK: begin
          if (outStream_TREADY) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_waitq.sv
// tb_lock_waitq: directed self-checking bench for lock_waitq (NUM_LOCKS=4).
// Define LOCK_WAITQ_TRYLOCK_EN for both bench and design to cover trylock.

module tb_lock_waitq;

  localparam logic [7:0] OP_LOCK   = 8'h04;
  localparam logic [7:0] OP_TRY    = 8'h05;
  localparam logic [7:0] OP_UNLOCK = 8'h06;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [63:0] inStream_TDATA = '0;
  logic        inStream_TVALID = 1'b0;
  logic [3:0]  inStream_TID = '0;
  logic        inStream_TREADY;
  logic [7:0]  outStream_TDATA;
  logic        outStream_TVALID;
  logic        outStream_TREADY = 1'b0;
  logic [3:0]  outStream_TDEST;

  int checks = 0;
  int errors = 0;

  lock_waitq #(.NUM_LOCKS(4)) dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .inStream_TDATA   (inStream_TDATA),
    .inStream_TVALID  (inStream_TVALID),
    .inStream_TID     (inStream_TID),
    .inStream_TREADY  (inStream_TREADY),
    .outStream_TDATA  (outStream_TDATA),
    .outStream_TVALID (outStream_TVALID),
    .outStream_TREADY (outStream_TREADY),
    .outStream_TDEST  (outStream_TDEST)
  );

  // Free-running clock, 10 time units per period.
  always #5 ap_clk = ~ap_clk;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Wait (bounded) for TREADY, then present one command and let it be accepted.
  task automatic applyStimulus(input logic [3:0] tid, input logic [7:0] op, input logic [7:0] id);
    int waitCnt;
    waitCnt = 0;
    while (inStream_TREADY !== 1'b1 && waitCnt < 20) begin
      @(posedge ap_clk); #1;
      waitCnt++;
    end
    checks++;
    if (inStream_TREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_wait: TREADY=%b, required 1", inStream_TREADY);
    end
    inStream_TID    = tid;
    inStream_TDATA  = {48'hA5A5_5A5A_0F0F, id, op};
    inStream_TVALID = 1'b1;
    @(posedge ap_clk); #1;
    inStream_TVALID = 1'b0;
    inStream_TDATA  = '0;
  endtask

  // After an accept edge, record at which edge TVALID / TREADY first read high
  // (0 = never within 6 edges) and consume one ack if it appears.
  task automatic checkOutput(output int ackLat, output int readyLat, output logic [7:0] data,
                             output logic [3:0] dest, output logic postValid);
    ackLat = 0; readyLat = 0; data = 8'h00; dest = 4'h0; postValid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge ap_clk);
      if (readyLat == 0 && inStream_TREADY === 1'b1) readyLat = k;
      if (outStream_TVALID === 1'b1) begin
        ackLat = k;
        data = outStream_TDATA;
        dest = outStream_TDEST;
        outStream_TREADY = 1'b1;
        @(posedge ap_clk); #1;
        outStream_TREADY = 1'b0;
        postValid = outStream_TVALID;
        break;
      end
    end
  endtask

  // Reset values while reset is held and the first cycle after release.
  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (inStream_TREADY !== 1'b0 || outStream_TVALID !== 1'b0 || outStream_TDATA !== 8'h00 || outStream_TDEST !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: tready=%b tvalid=%b tdata=%h tdest=%h, required 0 0 00 0",
               inStream_TREADY, outStream_TVALID, outStream_TDATA, outStream_TDEST);
    end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (inStream_TREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_tready: got %b, required 1", inStream_TREADY);
    end
  endtask

  // Uncontended lock: grant at the 2nd edge, dropped after one TREADY cycle.
  task automatic test_grant();
    int lat, rlat; logic [7:0] d; logic [3:0] t; logic pv;
    applyStimulus(4'd0, OP_LOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd0 || pv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL grant_id0: lat=%0d data=%h dest=%0d post=%b, required lat=2 data=01 dest=0 post=0", lat, d, t, pv);
    end
  endtask

  // Waiters queue silently and receive handoff grants in round-robin order.
  task automatic test_queue();
    int lat, rlat; logic [7:0] d; logic [3:0] t; logic pv;
    applyStimulus(4'd3, OP_LOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL queue_tid3: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
    applyStimulus(4'd9, OP_LOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL queue_tid9: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
    applyStimulus(4'd0, OP_UNLOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 3 || d !== 8'h01 || t !== 4'd3 || pv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL handoff_to3: lat=%0d data=%h dest=%0d post=%b, required lat=3 data=01 dest=3 post=0", lat, d, t, pv);
    end
    applyStimulus(4'd3, OP_UNLOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 3 || d !== 8'h01 || t !== 4'd9) begin
      errors++;
      $display("[TB] FAIL handoff_to9: lat=%0d data=%h dest=%0d, required lat=3 data=01 dest=9", lat, d, t);
    end
    applyStimulus(4'd9, OP_UNLOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL plain_unlock_tid9: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
  endtask

  // Non-owner unlock is ignored; out-of-range IDs are refused or ignored.
  task automatic test_nonowner_range();
    int lat, rlat; logic [7:0] d; logic [3:0] t; logic pv;
    applyStimulus(4'd0, OP_LOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd0) begin
      errors++;
      $display("[TB] FAIL regrant_id0: lat=%0d data=%h dest=%0d, required lat=2 data=01 dest=0", lat, d, t);
    end
    applyStimulus(4'd5, OP_UNLOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL nonowner_unlock: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
    applyStimulus(4'd0, OP_LOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd0) begin
      errors++;
      $display("[TB] FAIL owner_relock: lat=%0d data=%h dest=%0d, required lat=2 data=01 dest=0", lat, d, t);
    end
    applyStimulus(4'd6, OP_LOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL queue_tid6: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
    applyStimulus(4'd0, OP_UNLOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 3 || d !== 8'h01 || t !== 4'd6) begin
      errors++;
      $display("[TB] FAIL handoff_to6: lat=%0d data=%h dest=%0d, required lat=3 data=01 dest=6", lat, d, t);
    end
    applyStimulus(4'd6, OP_UNLOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL plain_unlock_tid6: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
    applyStimulus(4'd11, OP_LOCK, 8'd5);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h00 || t !== 4'd11) begin
      errors++;
      $display("[TB] FAIL range_refuse: lat=%0d data=%h dest=%0d, required lat=2 data=00 dest=11", lat, d, t);
    end
    applyStimulus(4'd11, OP_UNLOCK, 8'd7);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL range_unlock: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
  endtask

  // Round-robin search wraps from TID 15 back to TID 0.
  task automatic test_wrap();
    int lat, rlat; logic [7:0] d; logic [3:0] t; logic pv;
    applyStimulus(4'd14, OP_LOCK, 8'd1);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd14) begin
      errors++;
      $display("[TB] FAIL wrap_grant14: lat=%0d data=%h dest=%0d, required lat=2 data=01 dest=14", lat, d, t);
    end
    applyStimulus(4'd2, OP_LOCK, 8'd1);
    checkOutput(lat, rlat, d, t, pv);
    applyStimulus(4'd15, OP_LOCK, 8'd1);
    checkOutput(lat, rlat, d, t, pv);
    applyStimulus(4'd14, OP_UNLOCK, 8'd1);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 3 || d !== 8'h01 || t !== 4'd15) begin
      errors++;
      $display("[TB] FAIL wrap_to15: lat=%0d data=%h dest=%0d, required lat=3 data=01 dest=15", lat, d, t);
    end
    applyStimulus(4'd15, OP_UNLOCK, 8'd1);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 3 || d !== 8'h01 || t !== 4'd2) begin
      errors++;
      $display("[TB] FAIL wrap_to2: lat=%0d data=%h dest=%0d, required lat=3 data=01 dest=2", lat, d, t);
    end
    applyStimulus(4'd2, OP_UNLOCK, 8'd1);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL wrap_release: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
  endtask

  // Unknown opcodes are dropped; 0x05 is trylock only when the feature is built in.
  task automatic test_opcodes();
    int lat, rlat; logic [7:0] d; logic [3:0] t; logic pv;
    applyStimulus(4'd4, 8'h33, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL unknown_op: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
    applyStimulus(4'd1, OP_LOCK, 8'd2);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd1) begin
      errors++;
      $display("[TB] FAIL try_setup_grant: lat=%0d data=%h dest=%0d, required lat=2 data=01 dest=1", lat, d, t);
    end
    applyStimulus(4'd7, OP_TRY, 8'd2);
    checkOutput(lat, rlat, d, t, pv);
`ifdef LOCK_WAITQ_TRYLOCK_EN
    checks++;
    if (lat !== 2 || d !== 8'h00 || t !== 4'd7) begin
      errors++;
      $display("[TB] FAIL trylock_refuse: lat=%0d data=%h dest=%0d, required lat=2 data=00 dest=7", lat, d, t);
    end
`else
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL op05_dropped: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
`endif
    applyStimulus(4'd1, OP_UNLOCK, 8'd2);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL try_owner_unlock: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
`ifdef LOCK_WAITQ_TRYLOCK_EN
    applyStimulus(4'd7, OP_TRY, 8'd2);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd7) begin
      errors++;
      $display("[TB] FAIL trylock_free: lat=%0d data=%h dest=%0d, required lat=2 data=01 dest=7", lat, d, t);
    end
    applyStimulus(4'd7, OP_UNLOCK, 8'd2);
    checkOutput(lat, rlat, d, t, pv);
`endif
  endtask

  // A held ack stays stable under 10 cycles of backpressure and is consumed once.
  task automatic test_backpressure();
    applyStimulus(4'd8, OP_LOCK, 8'd3);
    @(negedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (outStream_TVALID !== 1'b1 || outStream_TDATA !== 8'h01 || outStream_TDEST !== 4'd8) begin
      errors++;
      $display("[TB] FAIL bp_first: tvalid=%b tdata=%h tdest=%0d, required 1 01 8",
               outStream_TVALID, outStream_TDATA, outStream_TDEST);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      checks++;
      if (outStream_TVALID !== 1'b1 || outStream_TDATA !== 8'h01 || outStream_TDEST !== 4'd8 || inStream_TREADY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: tvalid=%b tdata=%h tdest=%0d tready=%b, required 1 01 8 0",
                 i, outStream_TVALID, outStream_TDATA, outStream_TDEST, inStream_TREADY);
      end
    end
    outStream_TREADY = 1'b1;
    @(posedge ap_clk); #1;
    outStream_TREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      checks++;
      if (outStream_TVALID !== 1'b0 || inStream_TREADY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bp_consumed cycle %0d: tvalid=%b tready=%b, required 0 1",
                 i, outStream_TVALID, inStream_TREADY);
      end
    end
  endtask

  // Reset during ACK discards the ack and frees every lock and waiter.
  task automatic test_reset_in_ack();
    int lat, rlat; logic [7:0] d; logic [3:0] t; logic pv;
    applyStimulus(4'd4, OP_LOCK, 8'd3);
    checkOutput(lat, rlat, d, t, pv);
    applyStimulus(4'd1, OP_LOCK, 8'd0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (outStream_TVALID !== 1'b1 || outStream_TDEST !== 4'd1) begin
      errors++;
      $display("[TB] FAIL rst_ack_pre: tvalid=%b tdest=%0d, required 1 1", outStream_TVALID, outStream_TDEST);
    end
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    checks++;
    if (outStream_TVALID !== 1'b0 || outStream_TDATA !== 8'h00 || outStream_TDEST !== 4'h0 || inStream_TREADY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_ack_outputs: tvalid=%b tdata=%h tdest=%h tready=%b, required 0 00 0 0",
               outStream_TVALID, outStream_TDATA, outStream_TDEST, inStream_TREADY);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (inStream_TREADY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_ack_tready: got %b, required 1", inStream_TREADY);
    end
    applyStimulus(4'd2, OP_LOCK, 8'd0);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd2) begin
      errors++;
      $display("[TB] FAIL rst_id0_free: lat=%0d data=%h dest=%0d, required lat=2 data=01 dest=2", lat, d, t);
    end
    applyStimulus(4'd5, OP_LOCK, 8'd3);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 2 || d !== 8'h01 || t !== 4'd5) begin
      errors++;
      $display("[TB] FAIL rst_id3_free: lat=%0d data=%h dest=%0d, required lat=2 data=01 dest=5", lat, d, t);
    end
    applyStimulus(4'd5, OP_UNLOCK, 8'd3);
    checkOutput(lat, rlat, d, t, pv);
    checks++;
    if (lat !== 0 || rlat !== 2) begin
      errors++;
      $display("[TB] FAIL rst_pending_cleared: ackLat=%0d readyLat=%0d, required 0 2", lat, rlat);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] starting lock_waitq bench");
    test_reset();
    test_grant();
    test_queue();
    test_nonowner_range();
    test_wrap();
    test_opcodes();
    test_backpressure();
    test_reset_in_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
